bram_rr_arbiter: RTL and testbench
==================================

// Module: bram_rr_arbiter
// PURPOSE
//  Shares one single-port synchronous block RAM between two requesters (port 0, port 1).
//  Round-robin arbitration and one access in flight at a time. Drives the RAM's
//  cs/we/oe/address/din controls and returns registered read data to the winning requester.
//  Sits between client logic and one BRAM port.
// PARAMETERS
//  DATA_WIDTH     8  width of data words
//  ADDRESS_WIDTH  8  width of word address
// PORTS
//  clk          in   1     single clock, all state on posedge
//  rst          in   1     asynchronous, active-high reset
//  req_0/req_1  in   1     access request; held with stable we/addr/wdata until gnt
//  we_0/we_1    in   1     1 = write, 0 = read
//  addr_0/addr_1 in  AW    word address
//  wdata_0/wdata_1 in DW   write data
//  gnt_0/gnt_1  out  1     one-cycle pulse: request consumed
//  rvalid_0/rvalid_1 out 1 one-cycle pulse: rdata valid for that port
//  rdata        out  DW    registered read data, shared by both ports
//  mem_cs       out  1     RAM chip select
//  mem_we       out  1     RAM write enable
//  mem_oe       out  1     RAM output enable (read)
//  mem_address  out  AW    RAM address
//  mem_din      out  DW    RAM write data
//  mem_dout     in   DW    RAM read data, valid the cycle after a read command edge
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; last-winner register = 1 (port 0 wins first tie).
//  - FSM states: IDLE, CMD, RDWAIT, RESP.
//    IDLE: if req_0|req_1, pick the winner and latch its we/addr/wdata/id, then -> CMD.
//      Otherwise stay in IDLE.
//    CMD: mem_cs=1, mem_we=we, mem_oe=~we, mem_address/mem_din from the latch;
//      gnt_<id>=1. Write -> IDLE. Read -> RDWAIT.
//    RDWAIT: all mem_* are 0; capture mem_dout into rdata at the end of the cycle; -> RESP.
//    RESP: rvalid_<id>=1 and rdata is valid; -> IDLE.
//  - All mem_* and gnt/rvalid outputs are registered. They are 0 outside the states above.
//  - Round-robin: both requesting -> the port that is not the last winner wins.
//    A single requester wins regardless of history. last-winner updates on every IDLE->CMD.
//  - Latency from the IDLE edge that samples req:
//    gnt in the next cycle; for a read, rvalid 3 cycles after the sampling edge.
//  - Throughput: write 1 per 2 cycles; read 1 per 4 cycles.
//  - A requester drops req (or presents its next request) on the edge ending its gnt cycle.
//    A req still high in the following IDLE cycle is treated as a new request.
//  - rdata holds its value after RESP until the next read capture.
//  - req changes outside IDLE are ignored; only the IDLE-cycle sample matters.
//  - rst asserted mid-access: immediate return to IDLE with all outputs 0.
//    Any pending read is dropped (no rvalid). An in-flight write may or may not complete.
//  - Never more than one of mem_cs cycles, gnt, or rvalid active per cycle per port.
//    gnt_0 and gnt_1 are never high together.
// CONFIGURATION
//  BRAM_ARB_FIXED_PRIO_EN defined:
//    Fixed priority; port 0 always wins when both request. last-winner register removed.
//  Undefined (default): round-robin as above.
// TESTING
//  1 Reset: rst=1 mid-read -> all outputs 0 immediately; no rvalid after release.
//  2 Single write: req_0,we_0=1,addr_0=8'h05,wdata_0=8'hA5 -> next cycle mem_cs=1,mem_we=1,
//    mem_address=05,mem_din=A5,gnt_0=1.
//  3 Read-back: port 1 reads 05 after test 2 -> gnt_1 one cycle after sampling, mem_oe=1;
//    rvalid_1=1, rdata=A5, 3 cycles after the sampling edge.
//  4 Contention: req_0 and req_1 held continuously (writes) -> gnt alternates 0,1,0,1,
//    first gnt_0; with BRAM_ARB_FIXED_PRIO_EN defined -> gnt_0 only.
//  5 Back-to-back reads: port 0 reads 3 addresses, re-requesting on gnt -> 3 rvalid_0 pulses
//    4 cycles apart with the matching data.
//  6 Idle: no req for 20 cycles -> mem_cs, gnt_*, and rvalid_* stay 0; rdata unchanged.

Source files
------------

// File: rtl/bram_rr_arbiter_if.sv
// Requester-side and RAM-side signal bundle for bram_rr_arbiter.
// The arbiter uses the slave modport; the client/RAM environment uses master.
interface bram_rr_arbiter_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     req_0;
  logic                     req_1;
  logic                     we_0;
  logic                     we_1;
  logic [ADDRESS_WIDTH-1:0] addr_0;
  logic [ADDRESS_WIDTH-1:0] addr_1;
  logic [DATA_WIDTH-1:0]    wdata_0;
  logic [DATA_WIDTH-1:0]    wdata_1;
  logic                     gnt_0;
  logic                     gnt_1;
  logic                     rvalid_0;
  logic                     rvalid_1;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     mem_cs;
  logic                     mem_we;
  logic                     mem_oe;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_din;
  logic [DATA_WIDTH-1:0]    mem_dout;

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata,
    output mem_cs, mem_we, mem_oe, mem_address, mem_din
  );

  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, mem_dout,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata,
    input  mem_cs, mem_we, mem_oe, mem_address, mem_din
  );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Two-port arbiter sharing one single-port synchronous BRAM, one access in flight.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module bram_rr_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  bram_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     id_q, id_d;
  logic                     gnt_0_q, gnt_0_d;
  logic                     gnt_1_q, gnt_1_d;
  logic                     rvalid_0_q, rvalid_0_d;
  logic                     rvalid_1_q, rvalid_1_d;
  logic                     mem_cs_q, mem_cs_d;
  logic                     mem_we_q, mem_we_d;
  logic                     mem_oe_q, mem_oe_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]    mem_din_q, mem_din_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  logic                     any_req;
  logic                     win;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  assign any_req = bus.req_0 | bus.req_1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // Port 0 always wins a tie; win only matters while some port requests.
  always_comb begin
    win = ~bus.req_0;
  end
`else
  logic last_q, last_d;

  always_comb begin
    win = (bus.req_0 & bus.req_1) ? ~last_q : bus.req_1;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) begin
      last_d = win;
    end
  end

  // Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    sel_we    = win ? bus.we_1    : bus.we_0;
    sel_addr  = win ? bus.addr_1  : bus.addr_0;
    sel_wdata = win ? bus.wdata_1 : bus.wdata_0;
  end

  // The *_d outputs describe the cycle the FSM is entering, so every output
  // is a flop that lines up exactly with its state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    id_d          = id_q;
    rdata_d       = rdata_q;
    gnt_0_d       = 1'b0;
    gnt_1_d       = 1'b0;
    rvalid_0_d    = 1'b0;
    rvalid_1_d    = 1'b0;
    mem_cs_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_oe_d      = 1'b0;
    mem_address_d = '0;
    mem_din_d     = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = CMD;
          id_d          = win;
          mem_cs_d      = 1'b1;
          mem_we_d      = sel_we;
          mem_oe_d      = ~sel_we;
          mem_address_d = sel_addr;
          mem_din_d     = sel_wdata;
          gnt_0_d       = ~win;
          gnt_1_d       = win;
        end
      end
      CMD: begin
        state_d = mem_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // RAM output is valid now, one cycle after the read command edge.
        state_d    = RESP;
        rdata_d    = bus.mem_dout;
        rvalid_0_d = ~id_q;
        rvalid_1_d = id_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= 1'b0;
      gnt_0_q       <= 1'b0;
      gnt_1_q       <= 1'b0;
      rvalid_0_q    <= 1'b0;
      rvalid_1_q    <= 1'b0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      mem_address_q <= '0;
      mem_din_q     <= '0;
      rdata_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      id_q          <= id_d;
      gnt_0_q       <= gnt_0_d;
      gnt_1_q       <= gnt_1_d;
      rvalid_0_q    <= rvalid_0_d;
      rvalid_1_q    <= rvalid_1_d;
      mem_cs_q      <= mem_cs_d;
      mem_we_q      <= mem_we_d;
      mem_oe_q      <= mem_oe_d;
      mem_address_q <= mem_address_d;
      mem_din_q     <= mem_din_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.gnt_0       = gnt_0_q;
  assign bus.gnt_1       = gnt_1_q;
  assign bus.rvalid_0    = rvalid_0_q;
  assign bus.rvalid_1    = rvalid_1_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_cs      = mem_cs_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_oe      = mem_oe_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_din     = mem_din_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a behavioural single-port RAM model.
// Honours BRAM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_bram_rr_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  bram_rr_arbiter_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) bus ();

  bram_rr_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM: write on cs&we, read data appears the cycle after cs&oe.
  logic [7:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_we) ram[bus.mem_address] <= bus.mem_din;
    if (bus.mem_cs && bus.mem_oe) bus.mem_dout <= ram[bus.mem_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {gnt_0, gnt_1, rvalid_0, rvalid_1, mem_cs, mem_we, mem_oe}
  function automatic logic [6:0] flags();
    return {bus.gnt_0, bus.gnt_1, bus.rvalid_0, bus.rvalid_1,
            bus.mem_cs, bus.mem_we, bus.mem_oe};
  endfunction

  initial begin
    logic [7:0] rd_addr [3];
    logic [7:0] rd_data [3];
    logic       exp_g1;
    int         last_rv;

    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.addr_0 = 8'h00; bus.wdata_0 = 8'h00;
    bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.addr_1 = 8'h00; bus.wdata_1 = 8'h00;

    // Reset state
    step(); step();
    check("reset_flags", 32'(flags()), 32'h0);
    check("reset_addr", 32'(bus.mem_address), 32'h0);
    check("reset_rdata", 32'(bus.rdata), 32'h0);
    rst = 1'b0;
    step();

    // Single write from port 0: 05 <= A5
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 8'h05; bus.wdata_0 = 8'hA5;
    step();
    check("wr_flags", 32'(flags()), 32'b1000110);
    check("wr_addr", 32'(bus.mem_address), 32'h05);
    check("wr_din", 32'(bus.mem_din), 32'hA5);
    bus.req_0 = 1'b0;
    step();
    check("wr_idle_flags", 32'(flags()), 32'h0);
    check("wr_idle_addr", 32'(bus.mem_address), 32'h0);

    // Read-back from port 1
    bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 8'h05;
    step();
    check("rd_cmd_flags", 32'(flags()), 32'b0100101);
    check("rd_cmd_addr", 32'(bus.mem_address), 32'h05);
    bus.req_1 = 1'b0;
    step();
    check("rd_wait_flags", 32'(flags()), 32'h0);
    step();
    check("rd_resp_flags", 32'(flags()), 32'b0001000);
    check("rd_resp_data", 32'(bus.rdata), 32'hA5);
    step();
    check("rd_after_flags", 32'(flags()), 32'h0);
    check("rd_after_data", 32'(bus.rdata), 32'hA5);

    // Port 1 writes 30 <= C3
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 8'h30; bus.wdata_1 = 8'hC3;
    step();
    check("wr1_flags", 32'(flags()), 32'b0100110);
    check("wr1_din", 32'(bus.mem_din), 32'hC3);
    bus.req_1 = 1'b0;
    step();

    // Contention: both ports hold write requests
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 8'h10; bus.wdata_0 = 8'h11;
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 8'h20; bus.wdata_1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef BRAM_ARB_FIXED_PRIO_EN
      exp_g1 = 1'b0;
`else
      exp_g1 = (i % 2) == 1;
`endif
      check($sformatf("cont_gnt_%0d", i), {30'h0, bus.gnt_0, bus.gnt_1}, {30'h0, ~exp_g1, exp_g1});
      check($sformatf("cont_addr_%0d", i), 32'(bus.mem_address), exp_g1 ? 32'h20 : 32'h10);
      if (i == 3) begin
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
      end
      step();
      check($sformatf("cont_gap_%0d", i), 32'(flags()), 32'h0);
    end

    // Back-to-back reads from port 0, next request presented during gnt
    rd_addr[0] = 8'h05; rd_data[0] = 8'hA5;
    rd_addr[1] = 8'h10; rd_data[1] = 8'h11;
    rd_addr[2] = 8'h30; rd_data[2] = 8'hC3;
    last_rv = 0;
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = rd_addr[0];
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("b2b_gnt_%0d", k), 32'(flags()), 32'b1000101);
      check($sformatf("b2b_addr_%0d", k), 32'(bus.mem_address), 32'(rd_addr[k]));
      if (k < 2) bus.addr_0 = rd_addr[k + 1];
      else       bus.req_0 = 1'b0;
      step();
      check($sformatf("b2b_wait_%0d", k), 32'(flags()), 32'h0);
      step();
      check($sformatf("b2b_rvalid_%0d", k), 32'(flags()), 32'b0010000);
      check($sformatf("b2b_rdata_%0d", k), 32'(bus.rdata), 32'(rd_data[k]));
      if (k > 0) check($sformatf("b2b_spacing_%0d", k), 32'(cyc - last_rv), 32'd4);
      last_rv = cyc;
      step();
      check($sformatf("b2b_end_%0d", k), 32'(flags()), 32'h0);
    end

    // Idle for 20 cycles: nothing fires, rdata holds
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle_%0d", i), {25'h0, flags()}, 32'h0);
    end
    check("idle_rdata", 32'(bus.rdata), 32'hC3);

    // Reset in the middle of a port 0 read
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 8'h20;
    step();
    check("mid_cmd_flags", 32'(flags()), 32'b1000101);
    bus.req_0 = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_flags", 32'(flags()), 32'h0);
    check("mid_rst_addr", 32'(bus.mem_address), 32'h0);
    check("mid_rst_rdata", 32'(bus.rdata), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst_%0d", i), 32'(flags()), 32'h0);
    end

    // Last-winner restored by reset: first tie goes to port 0
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 8'h40; bus.wdata_0 = 8'h44;
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 8'h50; bus.wdata_1 = 8'h55;
    step();
    check("post_rst_tie_gnt", {30'h0, bus.gnt_0, bus.gnt_1}, 32'b10);
    check("post_rst_tie_din", 32'(bus.mem_din), 32'h44);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
